// File: rtl/battleship_pkg.sv
// Shared types and constants for the Battleship turn controller.
//   state_e      : controller state encoding
//   WORD_*       : display word codes (dispa/dispb values)
//   SEG_*        : active-low segment patterns, bit 7 = dp (always off)
//   word_glyph() : segment pattern for one character of a word
package battleship_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned WORD_W  = 3;
    localparam int unsigned SEG_W   = 8;
    localparam int unsigned DIGITS  = 4;

    typedef enum logic [STATE_W-1:0] {
        S_LOAD   = 3'd0,
        S_TURN_A = 3'd1,
        S_TURN_B = 3'd2,
        S_A_WIN  = 3'd3,
        S_B_WIN  = 3'd4
    } state_e;

    localparam logic [WORD_W-1:0] WORD_LOAD = 3'd0;
    localparam logic [WORD_W-1:0] WORD_FIRE = 3'd1;
    localparam logic [WORD_W-1:0] WORD_WAIT = 3'd2;
    localparam logic [WORD_W-1:0] WORD_WIN  = 3'd3;
    localparam logic [WORD_W-1:0] WORD_LOSE = 3'd4;

    localparam logic [SEG_W-1:0] SEG_L     = 8'hC7;
    localparam logic [SEG_W-1:0] SEG_O     = 8'hC0;
    localparam logic [SEG_W-1:0] SEG_A     = 8'h88;
    localparam logic [SEG_W-1:0] SEG_D     = 8'hA1;
    localparam logic [SEG_W-1:0] SEG_F     = 8'h8E;
    localparam logic [SEG_W-1:0] SEG_I     = 8'hFB;
    localparam logic [SEG_W-1:0] SEG_R     = 8'hAF;
    localparam logic [SEG_W-1:0] SEG_E     = 8'h86;
    localparam logic [SEG_W-1:0] SEG_W_CH  = 8'hD5;
    localparam logic [SEG_W-1:0] SEG_T     = 8'h87;
    localparam logic [SEG_W-1:0] SEG_N     = 8'hAB;
    localparam logic [SEG_W-1:0] SEG_S     = 8'h92;
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

    // Character idx counts from the leftmost digit (0) to the rightmost (3).
    function automatic logic [SEG_W-1:0] word_glyph(input logic [WORD_W-1:0] word,
                                                    input logic [1:0]        idx);
        logic [SEG_W-1:0] glyph;
        glyph = SEG_BLANK;
        case (word)
            WORD_LOAD: case (idx) 2'd0: glyph = SEG_L;    2'd1: glyph = SEG_O;
                                  2'd2: glyph = SEG_A;    default: glyph = SEG_D; endcase
            WORD_FIRE: case (idx) 2'd0: glyph = SEG_F;    2'd1: glyph = SEG_I;
                                  2'd2: glyph = SEG_R;    default: glyph = SEG_E; endcase
            WORD_WAIT: case (idx) 2'd0: glyph = SEG_W_CH; 2'd1: glyph = SEG_A;
                                  2'd2: glyph = SEG_I;    default: glyph = SEG_T; endcase
            WORD_WIN:  case (idx) 2'd0: glyph = SEG_W_CH; 2'd1: glyph = SEG_I;
                                  2'd2: glyph = SEG_N;    default: glyph = SEG_BLANK; endcase
            WORD_LOSE: case (idx) 2'd0: glyph = SEG_L;    2'd1: glyph = SEG_O;
                                  2'd2: glyph = SEG_S;    default: glyph = SEG_E; endcase
            default:   glyph = SEG_BLANK;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/battleship_game_ctrl_word_display.sv
// word_display: multiplexed 4-digit seven-segment driver for one status word.
//   clk, clr_n : clock, synchronous active-low reset (clears scan counter)
//   word_sel   : word code to show
//   seg        : active-low segments, seg[7] = dp (always 1)
//   an         : active-low digit enables, an[3] = leftmost
// seg/an are combinational from the scan counter and word_sel.
module word_display
    import battleship_pkg::*;
#(
    parameter int unsigned REFRESH_W = 18
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [WORD_W-1:0] word_sel,
    output logic [SEG_W-1:0]  seg,
    output logic [DIGITS-1:0] an
);

    logic [REFRESH_W-1:0] scan_cnt;
    logic [1:0]           digit;

    // Free-running scan counter; wraps from all-ones to zero.
    always_ff @(posedge clk) begin
        if (!clr_n) scan_cnt <= '0;
        else        scan_cnt <= scan_cnt + REFRESH_W'(1);
    end

    assign digit = scan_cnt[REFRESH_W-1 -: 2];

    // Digit 0 is the leftmost character, enabled by an[3].
    always_comb begin
        an = 4'b1111;
        case (digit)
            2'd0:    an = 4'b0111;
            2'd1:    an = 4'b1011;
            2'd2:    an = 4'b1101;
            default: an = 4'b1110;
        endcase
    end

    assign seg = word_glyph(word_sel, digit);

endmodule

// File: rtl/battleship_game_ctrl.sv
// battleship_game_ctrl: turn sequencer and local status display for one board.
//   clk, clr_n          : clock, synchronous active-low reset
//   btn_load            : both players' load buttons ANDed
//   btn2a, btn2b        : attack-commit buttons of A / B
//   oka, okb            : attack of A / B is valid
//   liva, livb          : A / B still has a ship cell
//   st                  : 0 in setup, 1 from play onward
//   ldr1a, ldr1b        : ship-register load enables (high in LOAD)
//   ldr2a, ldr2b        : one-cycle attack-register load strobes
//   dispa, dispb        : word codes for A / B
//   seg, an             : local display, driven by dispa
// Build option: define BS_EDGE_DETECT_EN to treat a press as a rising edge
// instead of a sampled high level.
module battleship_game_ctrl
    import battleship_pkg::*;
#(
    parameter int unsigned REFRESH_W = 18
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              btn_load,
    input  logic              btn2a,
    input  logic              btn2b,
    input  logic              oka,
    input  logic              okb,
    input  logic              liva,
    input  logic              livb,
    output logic              st,
    output logic              ldr1a,
    output logic              ldr1b,
    output logic              ldr2a,
    output logic              ldr2b,
    output logic [WORD_W-1:0] dispa,
    output logic [WORD_W-1:0] dispb,
    output logic [SEG_W-1:0]  seg,
    output logic [DIGITS-1:0] an
);

    localparam logic [STATE_W-1:0] ST_LOAD   = S_LOAD;
    localparam logic [STATE_W-1:0] ST_TURN_A = S_TURN_A;
    localparam logic [STATE_W-1:0] ST_TURN_B = S_TURN_B;
    localparam logic [STATE_W-1:0] ST_A_WIN  = S_A_WIN;
    localparam logic [STATE_W-1:0] ST_B_WIN  = S_B_WIN;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic               load_press;
    logic               a_press;
    logic               b_press;

`ifdef BS_EDGE_DETECT_EN
    logic [2:0] btn_q;

    // Previous-value flops keep sampling through reset so a button held
    // across reset release is not seen as a fresh press.
    always_ff @(posedge clk) begin
        btn_q <= {btn_load, btn2a, btn2b};
    end

    assign load_press = btn_load & ~btn_q[2];
    assign a_press    = btn2a    & ~btn_q[1];
    assign b_press    = btn2b    & ~btn_q[0];
`else
    assign load_press = btn_load;
    assign a_press    = btn2a;
    assign b_press    = btn2b;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!clr_n) state <= ST_LOAD;
        else        state <= state_nxt;
    end

    // Next state, Moore status outputs and Mealy attack strobes.
    always_comb begin
        state_nxt = state;
        st        = 1'b1;
        ldr1a     = 1'b0;
        ldr1b     = 1'b0;
        ldr2a     = 1'b0;
        ldr2b     = 1'b0;
        dispa     = WORD_LOAD;
        dispb     = WORD_LOAD;
        case (state)
            ST_LOAD: begin
                st    = 1'b0;
                ldr1a = 1'b1;
                ldr1b = 1'b1;
                if (load_press) state_nxt = ST_TURN_A;
            end
            ST_TURN_A: begin
                dispa = WORD_FIRE;
                dispb = WORD_WAIT;
                // Liveness outranks the attack; an invalid attack is dropped.
                if (!livb)              state_nxt = ST_A_WIN;
                else if (!liva)         state_nxt = ST_B_WIN;
                else if (a_press && oka) begin
                    ldr2a     = 1'b1;
                    state_nxt = ST_TURN_B;
                end
            end
            ST_TURN_B: begin
                dispa = WORD_WAIT;
                dispb = WORD_FIRE;
                if (!liva)              state_nxt = ST_B_WIN;
                else if (!livb)         state_nxt = ST_A_WIN;
                else if (b_press && okb) begin
                    ldr2b     = 1'b1;
                    state_nxt = ST_TURN_A;
                end
            end
            ST_A_WIN: begin
                dispa = WORD_WIN;
                dispb = WORD_LOSE;
            end
            ST_B_WIN: begin
                dispa = WORD_LOSE;
                dispb = WORD_WIN;
            end
            default: begin
                st        = 1'b0;
                state_nxt = ST_LOAD;
            end
        endcase
    end

    word_display #(
        .REFRESH_W (REFRESH_W)
    ) u_word_display (
        .clk      (clk),
        .clr_n    (clr_n),
        .word_sel (dispa),
        .seg      (seg),
        .an       (an)
    );

endmodule

// File: tb/tb_battleship_game_ctrl.sv
// Self-checking bench for battleship_game_ctrl with a 4-bit scan counter.
// Each cycle's expected outputs are queued when inputs are driven and are
// compared on the following falling edge.
module tb_battleship_game_ctrl;

    logic       clk = 1'b0;
    logic       clr_n, btn_load, btn2a, btn2b, oka, okb, liva, livb;
    logic       st, ldr1a, ldr1b, ldr2a, ldr2b;
    logic [2:0] dispa, dispb;
    logic [7:0] seg;
    logic [3:0] an;

    typedef struct {
        int         id;
        logic       st;
        logic       l2a;
        logic       l2b;
        logic [2:0] da;
        logic [2:0] db;
        logic [3:0] cnt;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         step_id  = 0;
    logic [3:0] cnt_m    = 4'd0;

    battleship_game_ctrl #(.REFRESH_W(4)) dut (
        .clk(clk), .clr_n(clr_n), .btn_load(btn_load), .btn2a(btn2a), .btn2b(btn2b),
        .oka(oka), .okb(okb), .liva(liva), .livb(livb), .st(st), .ldr1a(ldr1a),
        .ldr1b(ldr1b), .ldr2a(ldr2a), .ldr2b(ldr2b), .dispa(dispa), .dispb(dispb),
        .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic string word_str(input logic [2:0] code);
        case (code)
            3'd0:    return "LOAd";
            3'd1:    return "FirE";
            3'd2:    return "WAit";
            3'd3:    return "Win ";
            3'd4:    return "LOSE";
            default: return "    ";
        endcase
    endfunction

    function automatic logic [7:0] char_seg(input byte c);
        case (c)
            "L": return 8'hC7;  "O": return 8'hC0;  "A": return 8'h88;
            "d": return 8'hA1;  "F": return 8'h8E;  "i": return 8'hFB;
            "r": return 8'hAF;  "E": return 8'h86;  "W": return 8'hD5;
            "t": return 8'h87;  "n": return 8'hAB;  "S": return 8'h92;
            default: return 8'hFF;
        endcase
    endfunction

    // Queue this cycle's expectation, then advance one clock.
    task automatic step(input logic e_st, input logic e_l2a, input logic e_l2b,
                        input logic [2:0] e_da, input logic [2:0] e_db);
        exp_t e;
        e.id  = step_id;
        e.st  = e_st;
        e.l2a = e_l2a;
        e.l2b = e_l2b;
        e.da  = e_da;
        e.db  = e_db;
        e.cnt = cnt_m;
        step_id++;
        sb.push_back(e);
        @(posedge clk);
        cnt_m = clr_n ? cnt_m + 4'd1 : 4'd0;
        #1;
    endtask

    // Scoreboard consumer: compare the queued expectation mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t       e;
            string      w;
            logic [3:0] e_an;
            int         idx;
            e   = sb.pop_front();
            idx = int'(e.cnt[3:2]);
            w   = word_str(e.da);
            case (idx)
                0:       e_an = 4'b0111;
                1:       e_an = 4'b1011;
                2:       e_an = 4'b1101;
                default: e_an = 4'b1110;
            endcase
            check($sformatf("s%0d_st", e.id),    32'(st),    32'(e.st));
            check($sformatf("s%0d_ldr1a", e.id), 32'(ldr1a), 32'(!e.st));
            check($sformatf("s%0d_ldr1b", e.id), 32'(ldr1b), 32'(!e.st));
            check($sformatf("s%0d_ldr2a", e.id), 32'(ldr2a), 32'(e.l2a));
            check($sformatf("s%0d_ldr2b", e.id), 32'(ldr2b), 32'(e.l2b));
            check($sformatf("s%0d_dispa", e.id), 32'(dispa), 32'(e.da));
            check($sformatf("s%0d_dispb", e.id), 32'(dispb), 32'(e.db));
            check($sformatf("s%0d_an", e.id),    32'(an),    32'(e_an));
            check($sformatf("s%0d_seg", e.id),   32'(seg),   32'(char_seg(w[idx])));
        end
    end

    initial begin
        clr_n = 1'b0; btn_load = 1'b0; btn2a = 1'b0; btn2b = 1'b0;
        oka = 1'b0; okb = 1'b0; liva = 1'b1; livb = 1'b1;
        repeat (2) @(posedge clk);
        cnt_m = 4'd0;
        #1;
        clr_n = 1'b1;

        // Reset state and digit scan (4 cycles per digit).
        repeat (5) step(0, 0, 0, 3'd0, 3'd0);

        // Load -> TURN_A.
        btn_load = 1'b1;
        step(0, 0, 0, 3'd0, 3'd0);
        btn_load = 1'b0;
        step(1, 0, 0, 3'd1, 3'd2);

        // Invalid attack and opponent's button are ignored in TURN_A.
        btn2a = 1'b1; oka = 1'b0;
        step(1, 0, 0, 3'd1, 3'd2);
        btn2a = 1'b0; btn2b = 1'b1; okb = 1'b1;
        step(1, 0, 0, 3'd1, 3'd2);
        btn2b = 1'b0;

        // Valid attack by A; hold btn2a through B's turn and back.
        btn2a = 1'b1; oka = 1'b1;
        step(1, 1, 0, 3'd1, 3'd2);
        step(1, 0, 0, 3'd2, 3'd1);
        btn2b = 1'b1;
        step(1, 0, 1, 3'd2, 3'd1);
        btn2b = 1'b0;
`ifdef BS_EDGE_DETECT_EN
        step(1, 0, 0, 3'd1, 3'd2);
        btn2a = 1'b0;
        step(1, 0, 0, 3'd1, 3'd2);
        btn2a = 1'b1;
        step(1, 1, 0, 3'd1, 3'd2);
        btn2a = 1'b0;
`else
        step(1, 1, 0, 3'd1, 3'd2);
        btn2a = 1'b0;
`endif

        // TURN_B with livb dropping -> A_WIN, then buttons ignored.
        livb = 1'b0;
        step(1, 0, 0, 3'd2, 3'd1);
        step(1, 0, 0, 3'd3, 3'd4);
        btn_load = 1'b1; btn2a = 1'b1; btn2b = 1'b1; okb = 1'b1;
        step(1, 0, 0, 3'd3, 3'd4);
        step(1, 0, 0, 3'd3, 3'd4);
        btn_load = 1'b0; btn2a = 1'b0; btn2b = 1'b0;

        // Mid-game reset, then both lives lost in TURN_A -> A_WIN.
        clr_n = 1'b0;
        step(1, 0, 0, 3'd3, 3'd4);
        clr_n = 1'b1; livb = 1'b1;
        btn_load = 1'b1;
        step(0, 0, 0, 3'd0, 3'd0);
        btn_load = 1'b0; liva = 1'b0; livb = 1'b0;
        step(1, 0, 0, 3'd1, 3'd2);
        step(1, 0, 0, 3'd3, 3'd4);

        // Reset, then A dead with a valid attack pending -> B_WIN, no strobe.
        clr_n = 1'b0;
        step(1, 0, 0, 3'd3, 3'd4);
        clr_n = 1'b1; liva = 1'b1; livb = 1'b1; btn_load = 1'b1;
        step(0, 0, 0, 3'd0, 3'd0);
        btn_load = 1'b0; liva = 1'b0; btn2a = 1'b1; oka = 1'b1;
        step(1, 0, 0, 3'd1, 3'd2);
        btn2a = 1'b0;
        step(1, 0, 0, 3'd4, 3'd3);
        step(1, 0, 0, 3'd4, 3'd3);

        // One-edge reset out of B_WIN.
        clr_n = 1'b0;
        step(1, 0, 0, 3'd4, 3'd3);
        clr_n = 1'b1; liva = 1'b1;
        step(0, 0, 0, 3'd0, 3'd0);
        step(0, 0, 0, 3'd0, 3'd0);

        @(negedge clk);
        #1;
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
